// File: rtl/mux_pkg.sv
// Shared select encoding for the one-of-four data muxes.
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_case.sv
// 4:1 mux with a zero-latency combinational output f and a registered copy
// (f_r, s_r) captured from the same edge so the pair stays coherent.
module mux_case
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  sel_t             s,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_r,
    output sel_t             s_r
);

    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] r_f_r;
    sel_t             r_s_r;

    // Default branch only fires on an X/Z select; drives zero rather than holding.
    always_comb begin
        w_f = '0;
        case (s)
            SEL_I0:  w_f = i0;
            SEL_I1:  w_f = i1;
            SEL_I2:  w_f = i2;
            SEL_I3:  w_f = i3;
            default: w_f = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_r <= '0;
            r_s_r <= SEL_I0;
        end else begin
            r_f_r <= w_f;
            r_s_r <= s;
        end
    end

    assign f   = w_f;
    assign f_r = r_f_r;
    assign s_r = r_s_r;

endmodule

// File: tb/tb_mux_case.sv
// Directed bench for mux_case: WIDTH=1 and WIDTH=8 instances side by side.
module tb_mux_case;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
    logic [1:0] s  = 2'b00;
    logic       f, f_r;
    logic [1:0] s_r;

    logic [7:0] a0 = 8'h00, a1 = 8'h00, a2 = 8'h00, a3 = 8'h00;
    logic [1:0] s8 = 2'b00;
    logic [7:0] f8, f8_r;
    logic [1:0] s8_r;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_case #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .s(s), .f(f), .f_r(f_r), .s_r(s_r)
    );

    mux_case #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .i0(a0), .i1(a1), .i2(a2), .i3(a3),
        .s(s8), .f(f8), .f_r(f8_r), .s_r(s8_r)
    );

    task automatic test_reset();
        rst = 1'b1;
        i3 = 1'b1; s = 2'b11;
        a1 = 8'h5A; s8 = 2'b01;
        @(posedge clk); #1;
        n_total++;
        if (f_r !== 1'b0 || s_r !== 2'b00)
            $display("FAIL reset_w1: f_r=%b s_r=%b expected f_r=0 s_r=00", f_r, s_r);
        else n_pass++;
        n_total++;
        if (f8_r !== 8'h00 || s8_r !== 2'b00)
            $display("FAIL reset_w8: f_r=%h s_r=%b expected f_r=00 s_r=00", f8_r, s8_r);
        else n_pass++;
        n_total++;
        if (f !== 1'b1 || f8 !== 8'h5A)
            $display("FAIL f_during_reset: f=%b f8=%h expected f=1 f8=5a", f, f8);
        else n_pass++;
        i3 = 1'b0; s = 2'b00; a1 = 8'h00; s8 = 2'b00;
        rst = 1'b0;
    endtask

    // 16 checks: one-hot data on each input, select swept across all four.
    task automatic test_onehot();
        logic [3:0] hot;
        logic       exp;
        for (int a = 0; a < 4; a++) begin
            hot = 4'b0001 << a;
            {i3, i2, i1, i0} = hot;
            for (int sel = 0; sel < 4; sel++) begin
                s = sel[1:0];
                #1;
                exp = (a == sel);
                n_total++;
                if (f !== exp)
                    $display("FAIL onehot_i%0d_s%0d: f=%b expected %b", a, sel, f, exp);
                else n_pass++;
                #9;
            end
        end
    endtask

    task automatic test_registered();
        {i3, i2, i1, i0} = 4'b0000; s = 2'b00;
        @(posedge clk); #1;
        i2 = 1'b1; s = 2'b10;
        #1;
        n_total++;
        if (f !== 1'b1) $display("FAIL reg_f_immediate: f=%b expected 1", f);
        else n_pass++;
        n_total++;
        if (f_r !== 1'b0 || s_r !== 2'b00)
            $display("FAIL reg_before_edge: f_r=%b s_r=%b expected f_r=0 s_r=00", f_r, s_r);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (f_r !== 1'b1 || s_r !== 2'b10)
            $display("FAIL reg_after_edge: f_r=%b s_r=%b expected f_r=1 s_r=10", f_r, s_r);
        else n_pass++;
    endtask

    // Follows test_registered: f_r=1 with i2 selected.
    task automatic test_sync_reset();
        rst = 1'b1;
        #1;
        n_total++;
        if (f_r !== 1'b1) $display("FAIL rst_not_async: f_r=%b expected 1", f_r);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (f_r !== 1'b0 || s_r !== 2'b00)
            $display("FAIL rst_clears: f_r=%b s_r=%b expected f_r=0 s_r=00", f_r, s_r);
        else n_pass++;
        n_total++;
        if (f !== 1'b1) $display("FAIL rst_f_holds: f=%b expected 1", f);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (f_r !== 1'b1 || s_r !== 2'b10)
            $display("FAIL rst_release: f_r=%b s_r=%b expected f_r=1 s_r=10", f_r, s_r);
        else n_pass++;
        // Reset and a select change on the same edge: reset wins.
        rst = 1'b1; s = 2'b11;
        @(posedge clk); #1;
        n_total++;
        if (f_r !== 1'b0 || s_r !== 2'b00)
            $display("FAIL rst_wins: f_r=%b s_r=%b expected f_r=0 s_r=00", f_r, s_r);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_nonsel_toggle();
        {i3, i2, i1, i0} = 4'b0000; s = 2'b01;
        @(posedge clk); #2;
        for (int k = 0; k < 8; k++) begin
            i0 = ~i0; i2 = ~i2; i3 = ~i3;
            #1;
            n_total++;
            if (f !== 1'b0 || f_r !== 1'b0)
                $display("FAIL nonsel_%0d: f=%b f_r=%b expected 0 0", k, f, f_r);
            else n_pass++;
            #4;
        end
    endtask

    task automatic test_width8();
        logic [7:0] exp [4];
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF; exp[3] = 8'h00;
        a0 = 8'hA5; a1 = 8'h3C; a2 = 8'hFF; a3 = 8'h00;
        @(posedge clk); #1;
        for (int sel = 0; sel < 4; sel++) begin
            s8 = sel[1:0];
            #1;
            n_total++;
            if (f8 !== exp[sel])
                $display("FAIL w8_f_s%0d: f=%h expected %h", sel, f8, exp[sel]);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (f8_r !== exp[sel] || s8_r !== sel[1:0])
                $display("FAIL w8_fr_s%0d: f_r=%h s_r=%b expected %h %b",
                         sel, f8_r, s8_r, exp[sel], sel[1:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_registered();
        test_sync_reset();
        test_nonsel_toggle();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_case.md
Name: mux_case

Overview:
- 4:1 multiplexer built from a case statement on a 2-bit select.
- Combinational output `f` follows the selected data input with zero latency. A registered copy provides a timing-clean version for downstream synchronous logic.
- Leaf datapath block used wherever a small one-of-four data choice is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of both data outputs.

Ports:
- clk    input   1      system clock; rising edge active
- rst    input   1      synchronous reset, active-high
- i0     input   WIDTH  data input, selected when s = 2'b00
- i1     input   WIDTH  data input, selected when s = 2'b01
- i2     input   WIDTH  data input, selected when s = 2'b10
- i3     input   WIDTH  data input, selected when s = 2'b11
- s      input   2      select
- f      output  WIDTH  combinational mux output
- f_r    output  WIDTH  registered mux output
- s_r    output  2      registered select, aligned with f_r

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - With rst = 1 at a rising clk edge: f_r <= 0 and s_r <= 2'b00.
- Combinational path f:
  - Pure combinational case on s: 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
  - f does not depend on clk or rst; it stays valid during reset and with no clock running.
  - The case has a default branch that drives all-zero. It is reachable only when s contains X/Z. No latches are inferred.
  - Any change on s or on the selected input propagates to f in the same delta; there is no storage.
  - A change on a non-selected input has no effect on f.
- Registered path:
  - On each rising clk edge with rst = 0: f_r <= f (value before the edge) and s_r <= s.
  - Latency from a change on s or the selected input to f_r is one clock.
  - f_r and s_r always come from the same edge, so the pair is coherent.
- Reset and edge cases:
  - Reset mid-operation clears only f_r and s_r; f keeps tracking its inputs.
  - If rst and a select change arrive on the same edge, reset wins.
- Width rule:
  - All data paths are exactly WIDTH bits; no extension or truncation.
  - For WIDTH = 1 the block is a classic single-bit 4:1 mux.

Decomposition:
- Shared package mux_pkg:
  - Select encoding constants: SEL_I0 = 2'b00, SEL_I1 = 2'b01, SEL_I2 = 2'b10, SEL_I3 = 2'b11.
  - A sel_t typedef (2-bit logic).
- The combinational case lives in mux_case itself, written as an always_comb case using the package constants.
- The output register is an inline always_ff in the same module. No sub-module is needed.
- An optional reusable sub-module mux4_comb (case logic only) may be factored out if other blocks need an unregistered 4:1 mux.

Test Plan:
- One-hot sweep of i0 (WIDTH = 1):
  - Stimulus: i0 = 1, i1 = i2 = i3 = 0; step s through 00, 01, 10, 11, holding each 10 ns.
  - Required: f = 1, 0, 0, 0.
- Repeat the one-hot sweep with the 1 on i1, then i2, then i3:
  - Required: f = 1 only when s equals the active input's index (01, 10, 11 respectively), else 0.
  - 16 checks in total across all four one-hot patterns.
- Registered path:
  - Stimulus: rst = 0, i2 = 1, others 0, s = 10 applied before edge N.
  - Required: f = 1 immediately; f_r = 1 and s_r = 2'b10 after edge N, not before.
- Synchronous reset:
  - Stimulus: f_r = 1, assert rst for one edge while s and inputs are unchanged.
  - Required: f_r = 0 and s_r = 00 after the edge; f remains 1 throughout; f_r returns to 1 one edge after rst drops.
- Non-selected input toggling:
  - Stimulus: s = 01, i1 = 0; toggle i0, i2, i3 every 5 ns.
  - Required: f stays 0 and f_r stays 0.
- WIDTH = 8 variant:
  - Stimulus: i0 = 8'hA5, i1 = 8'h3C, i2 = 8'hFF, i3 = 8'h00; sweep s.
  - Required: f = A5, 3C, FF, 00, with f_r matching one clock later.
